group_credit_fifo: RTL and testbench

Next-generation group-synchronised FIFO for the SFTM→DPM forwarding path. It folds the separate credit counter into the buffer and widens the data path to LANES parallel channels. It adds short-group commit, group abort/rollback, and a sticky error with clear. Groups become visible to the reader only after commit, so the DPM never sees a partial group.

---
 rtl/group_credit_fifo.sv | 192 +++++++++++++++++++
 tb/tb_group_credit_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/group_credit_fifo.sv
// Group-synchronised credit FIFO: words become readable only once their group commits.
// Each group consumes one credit; popping a group's last word returns it.
module group_credit_fifo #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned LANES        = 4,
    parameter int unsigned GROUP_WORDS  = 32,
    parameter int unsigned DEPTH_GROUPS = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [DATA_W*LANES-1:0]   wr_data,
    input  logic                      group_done,
    input  logic                      wr_abort,
    input  logic                      rd_en,
    output logic [DATA_W*LANES-1:0]   rd_data,
    output logic                      rd_data_valid,
    output logic                      rd_last,
    input  logic                      bypass_mode,
    input  logic                      error_clr,
    output logic                      credit_available,
    output logic [CNT_W-1:0]          credits,
    output logic [CNT_W-1:0]          groups_ready,
    output logic [CNT_W-1:0]          count,
    output logic                      full,
    output logic                      empty,
    output logic                      error
);

    localparam int unsigned WORD_W = DATA_W * LANES;
    localparam int unsigned DEPTH  = GROUP_WORDS * DEPTH_GROUPS;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {StIdle, StFill} wr_state_e;

    wr_state_e        state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_new;
    logic [CNT_W-1:0] open_cnt_q, open_cnt_d, words_new;
    logic [CNT_W-1:0] credits_q, credits_d, groups_q, groups_d, count_q, count_d;
    logic             error_q, error_d;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0] last_q;

    logic pop, ret, take, abort, commit, err_set, mem_we, mem_wlast, last_set_prev;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(DEPTH - 1) : p - 1'b1;
    endfunction

    assign full             = (count_q + open_cnt_q) == CNT_W'(DEPTH);
    assign empty            = (count_q == '0);
    assign credits          = credits_q;
    assign credit_available = (credits_q != '0);
    assign groups_ready     = groups_q;
    assign count            = count_q;
    assign error            = error_q;

    always_comb begin
        state_d       = state_q;
        commit_ptr_d  = commit_ptr_q;
        take          = 1'b0;
        abort         = 1'b0;
        commit        = 1'b0;
        err_set       = 1'b0;
        mem_we        = 1'b0;
        mem_wlast     = 1'b0;
        last_set_prev = 1'b0;

        pop = rd_en && (count_q != '0) && !bypass_mode;
        ret = pop && last_q[rd_ptr_q];

        if (!bypass_mode) begin
            unique case (state_q)
                StIdle: begin
                    if (wr_en) begin
                        // A credit freed by this cycle's pop may be reused immediately.
                        if ((credits_q != '0) || ret) begin
                            mem_we    = 1'b1;
                            take      = 1'b1;
                            mem_wlast = group_done || (GROUP_WORDS == 1);
                            commit    = mem_wlast;
                            if (!commit) state_d = StFill;
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                end
                StFill: begin
                    if (wr_abort) begin
                        abort   = 1'b1;
                        state_d = StIdle;
                    end else if (wr_en && !full) begin
                        mem_we    = 1'b1;
                        mem_wlast = group_done || (open_cnt_q == CNT_W'(GROUP_WORDS - 1));
                        commit    = mem_wlast;
                    end else begin
                        if (wr_en) err_set = 1'b1;
                        if (group_done) begin
                            last_set_prev = 1'b1;
                            commit        = 1'b1;
                        end
                    end
                end
            endcase
        end

        words_new  = open_cnt_q + CNT_W'(mem_we);
        wr_ptr_new = mem_we ? ptr_inc(wr_ptr_q) : wr_ptr_q;

        if (abort) begin
            wr_ptr_d   = commit_ptr_q;
            open_cnt_d = '0;
        end else begin
            wr_ptr_d   = wr_ptr_new;
            open_cnt_d = commit ? '0 : words_new;
        end

        if (commit) begin
            commit_ptr_d = wr_ptr_new;
            state_d      = StIdle;
        end

        rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        credits_d = credits_q + CNT_W'(ret) + CNT_W'(abort) - CNT_W'(take);
        groups_d  = groups_q + CNT_W'(commit) - CNT_W'(ret);
        count_d   = count_q + (commit ? words_new : '0) - CNT_W'(pop);
        error_d   = error_clr ? 1'b0 : (error_q | err_set);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            open_cnt_q   <= '0;
            credits_q    <= CNT_W'(DEPTH_GROUPS);
            groups_q     <= '0;
            count_q      <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            open_cnt_q   <= open_cnt_d;
            credits_q    <= credits_d;
            groups_q     <= groups_d;
            count_q      <= count_d;
            error_q      <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else begin
            if (mem_we) last_q[wr_ptr_q] <= mem_wlast;
            if (last_set_prev) last_q[ptr_dec(wr_ptr_q)] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data       <= '0;
            rd_last       <= 1'b0;
            rd_data_valid <= 1'b0;
        end else if (bypass_mode) begin
            rd_data       <= wr_data;
            rd_last       <= group_done;
            rd_data_valid <= wr_en;
        end else if (pop) begin
            rd_data       <= mem[rd_ptr_q];
            rd_last       <= last_q[rd_ptr_q];
            rd_data_valid <= 1'b1;
        end else begin
            rd_last       <= 1'b0;
            rd_data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_group_credit_fifo.sv
// Directed table-driven bench for group_credit_fifo (4-word groups, 2 slots, 16-bit words).
module tb_group_credit_fifo;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LANES  = 2;
    localparam int unsigned GW     = 4;
    localparam int unsigned DG     = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WW     = DATA_W * LANES;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_en, group_done, wr_abort, rd_en, bypass_mode, error_clr;
    logic [WW-1:0]    wr_data;
    logic [WW-1:0]    rd_data;
    logic             rd_data_valid, rd_last, credit_available, full, empty, error;
    logic [CNT_W-1:0] credits, groups_ready, count;

    group_credit_fifo #(
        .DATA_W       (DATA_W),
        .LANES        (LANES),
        .GROUP_WORDS  (GW),
        .DEPTH_GROUPS (DG),
        .CNT_W        (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_en            (wr_en),
        .wr_data          (wr_data),
        .group_done       (group_done),
        .wr_abort         (wr_abort),
        .rd_en            (rd_en),
        .rd_data          (rd_data),
        .rd_data_valid    (rd_data_valid),
        .rd_last          (rd_last),
        .bypass_mode      (bypass_mode),
        .error_clr        (error_clr),
        .credit_available (credit_available),
        .credits          (credits),
        .groups_ready     (groups_ready),
        .count            (count),
        .full             (full),
        .empty            (empty),
        .error            (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we, gd, ab, re, by, ec;
        logic [WW-1:0] data;
        logic          e_valid, e_last, e_err, e_full;
        logic [WW-1:0] e_data;
        int unsigned   e_cred, e_gr, e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic we, input logic [WW-1:0] data, input logic gd,
                       input logic ab, input logic re, input logic by, input logic ec,
                       input logic ev, input logic [WW-1:0] ed, input logic el,
                       input int unsigned cred, input int unsigned gr, input int unsigned cnt,
                       input logic err, input logic fl);
        vec_t v;
        v.we = we; v.data = data; v.gd = gd; v.ab = ab; v.re = re; v.by = by; v.ec = ec;
        v.e_valid = ev; v.e_data = ed; v.e_last = el;
        v.e_cred = cred; v.e_gr = gr; v.e_cnt = cnt; v.e_err = err; v.e_full = fl;
        vecs.push_back(v);
    endtask

    task automatic check_status(input string tag, input int unsigned cred, input int unsigned gr,
                                input int unsigned cnt, input logic err, input logic fl);
        check({tag, " credits"}, credits, cred);
        check({tag, " credit_available"}, credit_available, (cred != 0) ? 1 : 0);
        check({tag, " groups_ready"}, groups_ready, gr);
        check({tag, " count"}, count, cnt);
        check({tag, " empty"}, empty, (cnt == 0) ? 1 : 0);
        check({tag, " error"}, error, err);
        check({tag, " full"}, full, fl);
    endtask

    initial begin
        rst_n = 1'b0;
        {wr_en, group_done, wr_abort, rd_en, bypass_mode, error_clr} = '0;
        wr_data = '0;

        //   we data     gd ab re by ec | ev rd_data  last cred gr cnt err full
        // Auto-commit of a full 4-word group, then drain it.
        add(1, 16'hA000, 0, 0, 0, 0, 0,   0, 16'h0,    0,   1, 0, 0, 0, 0);
        add(1, 16'hA001, 0, 0, 0, 0, 0,   0, 16'h0,    0,   1, 0, 0, 0, 0);
        add(1, 16'hA002, 0, 0, 0, 0, 0,   0, 16'h0,    0,   1, 0, 0, 0, 0);
        add(1, 16'hA003, 0, 0, 0, 0, 0,   0, 16'h0,    0,   1, 1, 4, 0, 0);
        add(0, 16'h0,    0, 0, 1, 0, 0,   1, 16'hA000, 0,   1, 1, 3, 0, 0);
        add(0, 16'h0,    0, 0, 1, 0, 0,   1, 16'hA001, 0,   1, 1, 2, 0, 0);
        add(0, 16'h0,    0, 0, 1, 0, 0,   1, 16'hA002, 0,   1, 1, 1, 0, 0);
        add(0, 16'h0,    0, 0, 1, 0, 0,   1, 16'hA003, 1,   2, 0, 0, 0, 0);
        // Short group committed by a lone group_done.
        add(1, 16'hB000, 0, 0, 0, 0, 0,   0, 16'h0,    0,   1, 0, 0, 0, 0);
        add(1, 16'hB001, 0, 0, 0, 0, 0,   0, 16'h0,    0,   1, 0, 0, 0, 0);
        add(0, 16'h0,    1, 0, 0, 0, 0,   0, 16'h0,    0,   1, 1, 2, 0, 0);
        add(0, 16'h0,    0, 0, 1, 0, 0,   1, 16'hB000, 0,   1, 1, 1, 0, 0);
        add(0, 16'h0,    0, 0, 1, 0, 0,   1, 16'hB001, 1,   2, 0, 0, 0, 0);
        // Two one-word groups exhaust credits; next open overflows.
        add(1, 16'h0F00, 1, 0, 0, 0, 0,   0, 16'h0,    0,   1, 1, 1, 0, 0);
        add(1, 16'h0F10, 1, 0, 0, 0, 0,   0, 16'h0,    0,   0, 2, 2, 0, 0);
        add(1, 16'h0C00, 0, 0, 0, 0, 0,   0, 16'h0,    0,   0, 2, 2, 1, 0);
        add(0, 16'h0,    0, 0, 0, 0, 1,   0, 16'h0,    0,   0, 2, 2, 0, 0);
        // Pop of a last word and a group open in the same cycle at zero credits.
        add(1, 16'hD000, 0, 0, 1, 0, 0,   1, 16'h0F00, 1,   0, 1, 1, 0, 0);
        add(1, 16'hD001, 1, 0, 0, 0, 0,   0, 16'h0,    0,   0, 2, 3, 0, 0);
        add(0, 16'h0,    0, 0, 1, 0, 0,   1, 16'h0F10, 1,   1, 1, 2, 0, 0);
        add(0, 16'h0,    0, 0, 1, 0, 0,   1, 16'hD000, 0,   1, 1, 1, 0, 0);
        add(0, 16'h0,    0, 0, 1, 0, 0,   1, 16'hD001, 1,   2, 0, 0, 0, 0);
        // Abort beats a same-cycle write; next group reuses E0's slot.
        add(1, 16'hE000, 0, 0, 0, 0, 0,   0, 16'h0,    0,   1, 0, 0, 0, 0);
        add(1, 16'hE001, 0, 0, 0, 0, 0,   0, 16'h0,    0,   1, 0, 0, 0, 0);
        add(1, 16'hEEEE, 0, 1, 0, 0, 0,   0, 16'h0,    0,   2, 0, 0, 0, 0);
        add(1, 16'h6000, 1, 0, 0, 0, 0,   0, 16'h0,    0,   1, 1, 1, 0, 0);
        add(0, 16'h0,    0, 0, 1, 0, 0,   1, 16'h6000, 1,   2, 0, 0, 0, 0);
        // Fill to capacity (rd_en on empty first word is ignored).
        add(1, 16'h0300, 0, 0, 1, 0, 0,   0, 16'h0,    0,   1, 0, 0, 0, 0);
        add(1, 16'h0301, 0, 0, 0, 0, 0,   0, 16'h0,    0,   1, 0, 0, 0, 0);
        add(1, 16'h0302, 0, 0, 0, 0, 0,   0, 16'h0,    0,   1, 0, 0, 0, 0);
        add(1, 16'h0303, 0, 0, 0, 0, 0,   0, 16'h0,    0,   1, 1, 4, 0, 0);
        add(1, 16'h0400, 0, 0, 0, 0, 0,   0, 16'h0,    0,   0, 1, 4, 0, 0);
        add(1, 16'h0401, 0, 0, 0, 0, 0,   0, 16'h0,    0,   0, 1, 4, 0, 0);
        add(1, 16'h0402, 0, 0, 0, 0, 0,   0, 16'h0,    0,   0, 1, 4, 0, 0);
        add(1, 16'h0403, 0, 0, 0, 0, 0,   0, 16'h0,    0,   0, 2, 8, 0, 1);
        add(1, 16'h0BAD, 0, 0, 0, 0, 0,   0, 16'h0,    0,   0, 2, 8, 1, 1);
        // error_clr wins over a same-cycle overflow.
        add(1, 16'h0BAE, 0, 0, 0, 0, 1,   0, 16'h0,    0,   0, 2, 8, 0, 1);
        // Bypass passes data through; storage untouched and rd_en ignored.
        add(1, 16'h1234, 0, 0, 0, 1, 0,   1, 16'h1234, 0,   0, 2, 8, 0, 1);
        add(0, 16'h0,    0, 0, 1, 1, 0,   0, 16'h0,    0,   0, 2, 8, 0, 1);
        add(0, 16'h0,    0, 0, 1, 0, 0,   1, 16'h0300, 0,   0, 2, 7, 0, 0);
        add(0, 16'h0,    0, 0, 1, 0, 0,   1, 16'h0301, 0,   0, 2, 6, 0, 0);
        add(0, 16'h0,    0, 0, 1, 0, 0,   1, 16'h0302, 0,   0, 2, 5, 0, 0);
        add(0, 16'h0,    0, 0, 1, 0, 0,   1, 16'h0303, 1,   1, 1, 4, 0, 0);
        add(1, 16'h0A0A, 0, 0, 0, 0, 0,   0, 16'h0,    0,   0, 1, 4, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset rd_data_valid", rd_data_valid, 0);
        check("reset rd_data", rd_data, 0);
        check_status("reset", DG, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            @(negedge clk);
            wr_en       = vecs[i].we;
            wr_data     = vecs[i].data;
            group_done  = vecs[i].gd;
            wr_abort    = vecs[i].ab;
            rd_en       = vecs[i].re;
            bypass_mode = vecs[i].by;
            error_clr   = vecs[i].ec;
            @(posedge clk);
            #1;
            tag = $sformatf("vec%0d", i);
            check({tag, " rd_data_valid"}, rd_data_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                check({tag, " rd_data"}, rd_data, vecs[i].e_data);
                check({tag, " rd_last"}, rd_last, vecs[i].e_last);
            end
            check_status(tag, vecs[i].e_cred, vecs[i].e_gr, vecs[i].e_cnt,
                         vecs[i].e_err, vecs[i].e_full);
        end

        // Asynchronous reset with a group open and stale rd_data present.
        @(negedge clk);
        {wr_en, group_done, wr_abort, rd_en, bypass_mode, error_clr} = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rd_data_valid", rd_data_valid, 0);
        check("async rd_data", rd_data, 0);
        check("async rd_last", rd_last, 0);
        check_status("async", DG, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
